data_ram_arbiter: RTL and testbench
===================================

# data_ram_arbiter

Two-port arbiter and sequencer for the shader core's data BlockRam. It shares the single data RAM between two requesters: the external host loader port and the core's load/store stage. It registers the winning command into the RAM and returns read data to the requester that issued the read, tagged with a valid strobe. It sits between the core state machine and the BlockRam, and contains the BlockRam instance.

## Interface
- `ADDRESS_WIDTH`, 16: byte address width; RAM word index is `addr[ADDRESS_WIDTH-1:2]`.
- `WORD_WIDTH`, 32: data word width.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: 0 = host strict priority; 1 = round-robin.
- `ext_req` in 1: host command valid.
- `ext_write` in 1: 1 = write, 0 = read.
- `ext_address` in ADDRESS_WIDTH: byte address.
- `ext_in_data` in WORD_WIDTH: write data.
- `ext_gnt` out 1: command accepted this cycle (combinational).
- `ext_rvalid` out 1: read data valid.
- `ext_out_data` out WORD_WIDTH: read data.
- `core_req`, `core_write`, `core_address`, `core_in_data`, `core_gnt`, `core_rvalid`, `core_out_data`: same as the `ext_*` set, for the core load/store port.

## Operation
- A command is accepted in a cycle where `req && gnt`. The requester must hold `req`, `write`, `address` and `in_data` stable until `gnt` is asserted.
- At most one grant per cycle. Arbitration is combinational on the current `req`, `run` and the registered `last_core` bit.
- `run=0`: `ext` wins whenever `ext_req=1`; otherwise `core` is granted if requesting.
- `run=1`: if only one requester is asking, it wins. If both are asking, the requester not granted last wins: `last_core=1` gives `ext`, `last_core=0` gives `core`.
- `last_core` updates only on a grant: set to 1 on a core grant, 0 on an ext grant.
- On acceptance, the command is registered into the RAM drive registers `ram_address`, `ram_write`, `ram_in_data` and the tag register `pend_id` / `pend_rd`.
- `ram_write` is a single-cycle pulse. It is cleared on any cycle with no accepted write.
- The read path is a 2-stage pipe.
  - Stage 1: the RAM drive registers are loaded.
  - Stage 2: the BlockRam's registered `read_data` is valid, and `rvalid` pulses for the tagged requester with `out_data = read_data`.
- `rvalid` is a one-cycle pulse. `out_data` is held from the last valid read, and is 0 after reset.
- Writes produce no `rvalid`.
- Back-to-back accepted reads (any mix of requesters) produce back-to-back `rvalid` pulses in acceptance order. There is no stall or back-pressure on read return.
- A read accepted in the cycle immediately after a write to the same word returns the new data. The write commits at the edge that ends stage 1, before the read samples.
- `address[1:0]` is ignored: no byte lanes, no misalignment fault.
- Reset mid-operation: in-flight reads are discarded (no `rvalid`), and a pending `ram_write` is cancelled.
- Reset values: `ext_gnt`/`core_gnt` follow `req` combinationally; `ram_write=0`; `ext_rvalid=core_rvalid=0`; `ext_out_data=core_out_data=0`; `last_core=0`; `pend_rd=0`.

## Timing
- Cycle N: `req=1`, `gnt=1` (accept).
- Edge ending N: RAM drive registers are loaded.
- Edge ending N+1: the BlockRam registers `read_data`, and a write commits.
- Cycle N+2: `rvalid=1` and `out_data` is valid, registered from the pipe tag.
- Read latency: 2 cycles from the accept cycle to `rvalid`. Throughput: 1 command per cycle total.
- A losing requester sees `gnt=0` and must retry. With `run=1`, the worst-case wait is 1 cycle.

## Structure
- Shared package `dram_pkg` holds:
  - `REQ_EXT=1'b0`, `REQ_CORE=1'b1` requester-ID constants.
  - Default width localparams.
  - A `pend_t` typedef (`valid`, `id`).
- The module instantiates one `BlockRam` (`WORD_WIDTH`, `ADDRESS_WIDTH`) with a common read/write address of `{2'b00, ram_address[ADDRESS_WIDTH-1:2]}`.
- The arbiter logic is kept inline; no further sub-modules.

## Test plan
- Host preload with `run=0`: ext writes 0xDEADBEEF to 0x0010, then reads 0x0010 -> `ext_rvalid` pulses 2 cycles after accept with 0xDEADBEEF; `core_rvalid` stays 0.
- Strict priority: `run=0`, both requesting for 3 cycles -> `ext_gnt=1` and `core_gnt=0` in each cycle; core is granted in the first cycle ext drops `req`.
- Round-robin: `run=1`, both hold read requests for 4 cycles after reset -> grants alternate core, ext, core, ext; the `rvalid` pulses follow in the same order with correct data per address.
- Write-then-read hazard: core writes 0x12345678 to 0x0040 (cycle N), ext reads 0x0040 (cycle N+1) -> `ext_out_data=0x12345678` at N+3.
- Address aliasing: write 0xA5A5A5A5 to 0x0103, read 0x0100 -> returns 0xA5A5A5A5.
- Reset mid-read: accept a core read, assert `reset` the next cycle -> no `core_rvalid`, `ram_write=0`, `out_data=0`; a fresh read after reset returns correct data with 2-cycle latency.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared definitions for the data RAM arbiter: requester IDs, default
// widths and the read-return tag carried down the pipe.
package dram_pkg;

  // Requester identifiers carried with every accepted read
  localparam logic REQ_EXT  = 1'b0;
  localparam logic REQ_CORE = 1'b1;

  // Default widths
  localparam int DEF_ADDRESS_WIDTH = 16;
  localparam int DEF_WORD_WIDTH    = 32;

  // Byte address bits below this index select a byte inside a word
  localparam int WORD_LSB = 2;

  // Read-return tag: a read is in flight and which port issued it
  typedef struct packed {
    logic valid;
    logic id;
  } pend_t;

  // True when the tag marks a read owned by the given requester
  function automatic logic rd_for(input pend_t p, input logic id);
    return p.valid && (p.id == id);
  endfunction

endpackage

// File: rtl/data_ram_arbiter_block_ram.sv
// Single-port word RAM with registered read data. The read samples the
// array before a same-edge write lands (read-first).
module BlockRam #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     write_enable,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [WORD_WIDTH-1:0]    write_data,
  output logic [WORD_WIDTH-1:0]    read_data
);

  localparam int DEPTH = 2 ** (ADDRESS_WIDTH - 2);

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [WORD_WIDTH-1:0] read_data_q;
  logic [ADDRESS_WIDTH-3:0] word_index;
  logic unused_addr_hi;

  // The two top address bits are always zero from the arbiter
  assign word_index     = address[ADDRESS_WIDTH-3:0];
  assign unused_addr_hi = ^address[ADDRESS_WIDTH-1:ADDRESS_WIDTH-2];

  // Commit writes and register the addressed word every cycle
  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem[word_index] <= write_data;
    end
    read_data_q <= mem[word_index];
  end

  assign read_data = read_data_q;

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares the shader core's data BlockRam between the host loader port and
// the core load/store port. One command is accepted per cycle; read data
// returns two cycles after acceptance on the port that issued it.
module data_ram_arbiter
  import dram_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int WORD_WIDTH    = DEF_WORD_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     ext_req,
  input  logic                     ext_write,
  input  logic [ADDRESS_WIDTH-1:0] ext_address,
  input  logic [WORD_WIDTH-1:0]    ext_in_data,
  output logic                     ext_gnt,
  output logic                     ext_rvalid,
  output logic [WORD_WIDTH-1:0]    ext_out_data,
  input  logic                     core_req,
  input  logic                     core_write,
  input  logic [ADDRESS_WIDTH-1:0] core_address,
  input  logic [WORD_WIDTH-1:0]    core_in_data,
  output logic                     core_gnt,
  output logic                     core_rvalid,
  output logic [WORD_WIDTH-1:0]    core_out_data
);

  // Arbitration history
  logic last_core_q, last_core_d;

  // Stage 1: RAM drive registers and the read tag
  logic [ADDRESS_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [WORD_WIDTH-1:0]    ram_in_data_q, ram_in_data_d;
  logic                     ram_write_q, ram_write_d;
  logic                     pend_rd_q, pend_rd_d;
  logic                     pend_id_q, pend_id_d;

  // Stage 2: tag aligned with the RAM's registered read data
  pend_t rsp_q, rsp_d;

  // Last returned word per port, held between read pulses
  logic [WORD_WIDTH-1:0] ext_hold_q, ext_hold_d;
  logic [WORD_WIDTH-1:0] core_hold_q, core_hold_d;

  logic [WORD_WIDTH-1:0]    read_data;
  logic [ADDRESS_WIDTH-1:0] ram_word_address;
  logic                     ram_we;
  logic                     unused_byte_lane;

  // Grant: host first when run=0; on contention with run=1 the port that
  // was not granted last wins
  always_comb begin
    ext_gnt  = 1'b0;
    core_gnt = 1'b0;
    if (ext_req && core_req) begin
      if (run && !last_core_q) begin
        core_gnt = 1'b1;
      end else begin
        ext_gnt = 1'b1;
      end
    end else begin
      ext_gnt  = ext_req;
      core_gnt = core_req;
    end
  end

  // Route the winning command into the RAM drive registers and tag it
  always_comb begin
    ram_address_d = ram_address_q;
    ram_in_data_d = ram_in_data_q;
    ram_write_d   = 1'b0;
    pend_rd_d     = 1'b0;
    pend_id_d     = pend_id_q;
    last_core_d   = last_core_q;
    if (core_gnt) begin
      ram_address_d = core_address;
      ram_in_data_d = core_in_data;
      ram_write_d   = core_write;
      pend_rd_d     = !core_write;
      pend_id_d     = REQ_CORE;
      last_core_d   = 1'b1;
    end else if (ext_gnt) begin
      ram_address_d = ext_address;
      ram_in_data_d = ext_in_data;
      ram_write_d   = ext_write;
      pend_rd_d     = !ext_write;
      pend_id_d     = REQ_EXT;
      last_core_d   = 1'b0;
    end
  end

  // Advance the read tag and steer returned data to its owner
  always_comb begin
    rsp_d.valid   = pend_rd_q;
    rsp_d.id      = pend_id_q;
    ext_rvalid    = rd_for(rsp_q, REQ_EXT);
    core_rvalid   = rd_for(rsp_q, REQ_CORE);
    ext_hold_d    = ext_rvalid  ? read_data : ext_hold_q;
    core_hold_d   = core_rvalid ? read_data : core_hold_q;
    ext_out_data  = ext_hold_d;
    core_out_data = core_hold_d;
  end

  // Control state: cleared by reset so in-flight reads and writes vanish
  always_ff @(posedge clock) begin
    if (reset) begin
      last_core_q <= 1'b0;
      ram_write_q <= 1'b0;
      pend_rd_q   <= 1'b0;
      rsp_q       <= '0;
      ext_hold_q  <= '0;
      core_hold_q <= '0;
    end else begin
      last_core_q <= last_core_d;
      ram_write_q <= ram_write_d;
      pend_rd_q   <= pend_rd_d;
      rsp_q       <= rsp_d;
      ext_hold_q  <= ext_hold_d;
      core_hold_q <= core_hold_d;
    end
  end

  // Data registers: only meaningful when qualified by the control flops
  always_ff @(posedge clock) begin
    ram_address_q <= ram_address_d;
    ram_in_data_q <= ram_in_data_d;
    pend_id_q     <= pend_id_d;
  end

  // Word addressing drops the byte offset; a write still pending when
  // reset arrives must not reach the array
  assign ram_word_address = {2'b00, ram_address_q[ADDRESS_WIDTH-1:WORD_LSB]};
  assign ram_we           = ram_write_q && !reset;
  assign unused_byte_lane = ^ram_address_q[WORD_LSB-1:0];

  BlockRam #(
    .WORD_WIDTH    (WORD_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_ram (
    .clock        (clock),
    .write_enable (ram_we),
    .address      (ram_word_address),
    .write_data   (ram_in_data_q),
    .read_data    (read_data)
  );

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Scoreboard bench for data_ram_arbiter: a word-array reference model
// predicts grants and read returns; a monitor checks every returned word.
module tb_data_ram_arbiter;

  localparam int AW = 16;
  localparam int WW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic          ext_req = 1'b0, ext_write = 1'b0;
  logic [AW-1:0] ext_address = '0;
  logic [WW-1:0] ext_in_data = '0;
  logic          core_req = 1'b0, core_write = 1'b0;
  logic [AW-1:0] core_address = '0;
  logic [WW-1:0] core_in_data = '0;
  logic          ext_gnt, ext_rvalid, core_gnt, core_rvalid;
  logic [WW-1:0] ext_out_data, core_out_data;

  data_ram_arbiter dut (
    .clock(clock), .reset(reset), .run(run),
    .ext_req(ext_req), .ext_write(ext_write), .ext_address(ext_address),
    .ext_in_data(ext_in_data), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
    .ext_out_data(ext_out_data),
    .core_req(core_req), .core_write(core_write), .core_address(core_address),
    .core_in_data(core_in_data), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_out_data(core_out_data)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit            id;
    logic [WW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  logic [WW-1:0] mem [int];
  bit            m_last_core;
  logic [WW-1:0] m_last [2];
  bit            wr_undo_v;
  int            wr_undo_idx;
  logic [WW-1:0] wr_undo_old;
  bit            e_acc, c_acc;
  bit            mon_en = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  // Reference: memory as a word array indexed by byte address / 4
  task automatic model_accept(input bit id, input bit wr, input logic [AW-1:0] addr,
                              input logic [WW-1:0] data);
    int   idx = int'(addr >> 2);
    exp_t e;
    if (wr) begin
      wr_undo_v   = 1'b1;
      wr_undo_idx = idx;
      wr_undo_old = mem[idx];
      mem[idx]    = data;
    end else begin
      e.id   = id;
      e.data = mem[idx];
      e.due  = cyc + 2;
      sb.push_back(e);
    end
  endtask

  // One clock cycle: predict the winner, check grants, apply to the model
  task automatic step();
    bit eg, cg;
    @(negedge clock);
    if (!run) begin
      eg = ext_req;
      cg = core_req && !ext_req;
    end else if (ext_req && core_req) begin
      eg = m_last_core;
      cg = !m_last_core;
    end else begin
      eg = ext_req;
      cg = core_req;
    end
    chk("ext_gnt", {31'd0, ext_gnt}, {31'd0, eg});
    chk("core_gnt", {31'd0, core_gnt}, {31'd0, cg});
    wr_undo_v = 1'b0;
    e_acc = eg && !reset;
    c_acc = cg && !reset;
    if (e_acc) begin
      model_accept(1'b0, ext_write, ext_address, ext_in_data);
      m_last_core = 1'b0;
    end
    if (c_acc) begin
      model_accept(1'b1, core_write, core_address, core_in_data);
      m_last_core = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    ext_req  = 1'b0;
    core_req = 1'b0;
    repeat (n) step();
  endtask

  // Drive one port alone until its command is accepted
  task automatic issue(input bit id, input bit wr, input logic [AW-1:0] a, input logic [WW-1:0] d);
    int n = 0;
    if (id) begin
      core_req = 1'b1; core_write = wr; core_address = a; core_in_data = d;
    end else begin
      ext_req = 1'b1; ext_write = wr; ext_address = a; ext_in_data = d;
    end
    do begin
      step();
      n++;
    end while (!(id ? c_acc : e_acc) && n < 10);
    n_checks++;
    if (!(id ? c_acc : e_acc)) begin
      n_fail++;
      $display("FAIL issue_timeout at cycle %0d: got no grant, expected grant within 10 cycles", cyc);
    end
    if (id) core_req = 1'b0; else ext_req = 1'b0;
  endtask

  // Two-cycle reset: drops in-flight reads and an unfinished write
  task automatic do_reset(input bit with_req);
    if (wr_undo_v) mem[wr_undo_idx] = wr_undo_old;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].due > cyc) sb.delete(i);
    reset = 1'b1;
    ext_req = with_req; ext_write = 1'b0; ext_address = 16'h0008;
    core_req = 1'b0;
    step();
    m_last_core = 1'b0;
    m_last[0] = '0;
    m_last[1] = '0;
    ext_req = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Monitor: every rvalid must match the oldest expected return
  always @(negedge clock) begin
    if (mon_en) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].due < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_rvalid at cycle %0d: got none, expected id %0d data %h due %0d",
                 cyc, sb[0].id, sb[0].data, sb[0].due);
        void'(sb.pop_front());
      end
      if (ext_rvalid && core_rvalid)
        chk("dual_rvalid", 32'd1, 32'd0);
      if (ext_rvalid || core_rvalid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", {30'd0, core_rvalid, ext_rvalid}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rvalid_port", {31'd0, core_rvalid}, {31'd0, e.id});
          chk("rvalid_latency", cyc, e.due);
          chk("read_data", e.id ? core_out_data : ext_out_data, e.data);
          m_last[e.id] = e.data;
        end
      end
      if (!ext_rvalid)  chk("ext_out_hold", ext_out_data, m_last[0]);
      if (!core_rvalid) chk("core_out_hold", core_out_data, m_last[1]);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog at cycle %0d: got no end of test, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit e_busy, c_busy;
    @(posedge clock);
    #1;
    do_reset(1'b0);
    mon_en = 1'b1;
    chk("reset_ext_rvalid", {31'd0, ext_rvalid}, 32'd0);
    chk("reset_core_rvalid", {31'd0, core_rvalid}, 32'd0);
    chk("reset_ext_out", ext_out_data, 32'd0);
    chk("reset_core_out", core_out_data, 32'd0);

    // Preload the words used below through the host port
    run = 1'b0;
    for (int i = 0; i < 128; i++) issue(1'b0, 1'b1, AW'(i * 4), $urandom);

    // Host write then read back
    issue(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF);
    issue(1'b0, 1'b0, 16'h0010, 32'h0);
    idle(3);

    // Strict priority: host holds off the core until it drops req
    ext_req = 1'b1; ext_write = 1'b0; ext_address = 16'h0020;
    core_req = 1'b1; core_write = 1'b0; core_address = 16'h0024;
    repeat (3) step();
    ext_req = 1'b0;
    step();
    idle(3);

    // Round-robin from reset: core, ext, core, ext
    do_reset(1'b1);
    run = 1'b1;
    ext_req = 1'b1; ext_write = 1'b0; ext_address = 16'h0030;
    core_req = 1'b1; core_write = 1'b0; core_address = 16'h0034;
    for (int i = 0; i < 4; i++) begin
      step();
      if (e_acc) ext_address = ext_address + 16'h0008;
      if (c_acc) core_address = core_address + 16'h0008;
    end
    idle(3);

    // Write followed immediately by a read of the same word
    run = 1'b0;
    core_req = 1'b1; core_write = 1'b1; core_address = 16'h0040; core_in_data = 32'h12345678;
    step();
    core_req = 1'b0;
    ext_req = 1'b1; ext_write = 1'b0; ext_address = 16'h0040;
    step();
    idle(3);

    // Byte offset ignored
    issue(1'b1, 1'b1, 16'h0103, 32'hA5A5A5A5);
    issue(1'b0, 1'b0, 16'h0100, 32'h0);
    idle(3);

    // Reset right after a read is accepted
    issue(1'b1, 1'b0, 16'h0040, 32'h0);
    do_reset(1'b0);
    chk("post_reset_core_out", core_out_data, 32'd0);
    chk("post_reset_ext_out", ext_out_data, 32'd0);
    issue(1'b1, 1'b0, 16'h0040, 32'h0);
    idle(3);

    // Reset right after a write is accepted: the write must not land
    issue(1'b0, 1'b1, 16'h0044, 32'hCAFEF00D);
    do_reset(1'b0);
    issue(1'b0, 1'b0, 16'h0044, 32'h0);
    idle(3);

    // Randomized traffic on both ports
    run = 1'b1;
    e_busy = 1'b0;
    c_busy = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!e_busy && $urandom_range(0, 2) == 0) begin
        e_busy = 1'b1;
        ext_write = $urandom_range(0, 1) == 1;
        ext_address = AW'($urandom_range(0, 511));
        ext_in_data = $urandom;
      end
      if (!c_busy && $urandom_range(0, 2) == 0) begin
        c_busy = 1'b1;
        core_write = $urandom_range(0, 1) == 1;
        core_address = AW'($urandom_range(0, 511));
        core_in_data = $urandom;
      end
      if ($urandom_range(0, 49) == 0) run = !run;
      ext_req = e_busy;
      core_req = c_busy;
      step();
      if (e_acc) e_busy = 1'b0;
      if (c_acc) c_busy = 1'b0;
    end
    idle(4);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
